cache_line_refill: RTL

//   Line-fill controller sitting between the direct-mapped cache and main memory.
//   On a cache miss it fetches the whole 16-word line from word-addressed memory,

---
 rtl/cache_line_refill_if.sv | 44 ++++
 rtl/cache_line_refill.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cache_line_refill_if.sv
// Bus bundle between the line-fill controller, the cache arrays, the miss source and memory.
// master = controller side, slave = cache/memory side.
interface cache_line_refill_if #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) ();
  logic                miss_valid;
  logic                miss_ready;
  logic [ADDR_W-1:0]   miss_addr;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;
  logic                fill_we;
  logic [INDEX_W-1:0]  fill_index;
  logic [OFFSET_W-1:0] fill_offset;
  logic [DATA_W-1:0]   fill_data;
  logic                tag_we;
  logic [INDEX_W-1:0]  tag_index;
  logic [TAG_W-1:0]    tag_data;
  logic                tag_valid;
  logic                done;
  logic [DATA_W-1:0]   done_data;
  logic                busy;

  modport master (
    input  miss_valid, miss_addr, mem_rvalid, mem_rdata,
    output miss_ready, mem_req, mem_addr,
    output fill_we, fill_index, fill_offset, fill_data,
    output tag_we, tag_index, tag_data, tag_valid,
    output done, done_data, busy
  );

  modport slave (
    output miss_valid, miss_addr, mem_rvalid, mem_rdata,
    input  miss_ready, mem_req, mem_addr,
    input  fill_we, fill_index, fill_offset, fill_data,
    input  tag_we, tag_index, tag_data, tag_valid,
    input  done, done_data, busy
  );
endinterface

// File: rtl/cache_line_refill.sv
// Line-fill controller: on a miss, invalidates the tag, fetches all words of the line one
// request at a time, writes them into the data array, revalidates the tag and returns the critical word.
module cache_line_refill #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_line_refill_if.master  bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORDS = 2 ** OFFSET_W;
  localparam int K_W   = OFFSET_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INVAL, S_REQ, S_WAIT, S_FLUSH, S_TAG, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [K_W-1:0]      k_q, k_d;

  logic                fill_we_q, fill_we_d;
  logic [INDEX_W-1:0]  fill_index_q, fill_index_d;
  logic [OFFSET_W-1:0] fill_offset_q, fill_offset_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                tag_we_q, tag_we_d;
  logic [INDEX_W-1:0]  tag_index_q, tag_index_d;
  logic [TAG_W-1:0]    tag_data_q, tag_data_d;
  logic                tag_valid_q, tag_valid_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   done_data_q, done_data_d;

  logic beat;
  logic last_beat;

  assign beat      = (state_q == S_WAIT) && bus.mem_rvalid;
  assign last_beat = (k_q == K_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tag_q         <= '0;
      index_q       <= '0;
      offset_q      <= '0;
      k_q           <= '0;
      fill_we_q     <= 1'b0;
      fill_index_q  <= '0;
      fill_offset_q <= '0;
      fill_data_q   <= '0;
      tag_we_q      <= 1'b0;
      tag_index_q   <= '0;
      tag_data_q    <= '0;
      tag_valid_q   <= 1'b0;
      done_q        <= 1'b0;
      done_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      tag_q         <= tag_d;
      index_q       <= index_d;
      offset_q      <= offset_d;
      k_q           <= k_d;
      fill_we_q     <= fill_we_d;
      fill_index_q  <= fill_index_d;
      fill_offset_q <= fill_offset_d;
      fill_data_q   <= fill_data_d;
      tag_we_q      <= tag_we_d;
      tag_index_q   <= tag_index_d;
      tag_data_q    <= tag_data_d;
      tag_valid_q   <= tag_valid_d;
      done_q        <= done_d;
      done_data_q   <= done_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    offset_d = offset_q;
    k_d      = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) begin
          state_d  = S_INVAL;
          tag_d    = bus.miss_addr[ADDR_W-1 -: TAG_W];
          index_d  = bus.miss_addr[OFFSET_W +: INDEX_W];
          offset_d = bus.miss_addr[OFFSET_W-1:0];
          k_d      = '0;
        end
      end
      S_INVAL: state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          if (last_beat) begin
            state_d = S_FLUSH;
          end else begin
            k_d     = k_q + K_W'(1);
            state_d = S_REQ;
          end
        end
      end
      // FLUSH lets the registered last fill_we land before the tag is revalidated.
      S_FLUSH: state_d = S_TAG;
      S_TAG:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    fill_we_d     = beat;
    fill_offset_d = beat ? k_q[OFFSET_W-1:0] : '0;
    fill_data_d   = beat ? bus.mem_rdata : '0;
    fill_index_d  = (state_d != S_IDLE) ? index_d : '0;
    tag_index_d   = (state_d != S_IDLE) ? index_d : '0;
    tag_we_d      = (state_d == S_INVAL) || (state_d == S_TAG);
    tag_valid_d   = (state_d == S_TAG);
    tag_data_d    = tag_we_d ? tag_d : '0;
    done_d        = (state_d == S_DONE);
    done_data_d   = (beat && (k_q == {1'b0, offset_q})) ? bus.mem_rdata : done_data_q;
  end

  assign bus.miss_ready  = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.mem_req     = (state_q == S_REQ);
  assign bus.mem_addr    = (state_q == S_REQ)
                           ? ({tag_q, index_q, {OFFSET_W{1'b0}}} + ADDR_W'(k_q))
                           : '0;
  assign bus.fill_we     = fill_we_q;
  assign bus.fill_index  = fill_index_q;
  assign bus.fill_offset = fill_offset_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.tag_we      = tag_we_q;
  assign bus.tag_index   = tag_index_q;
  assign bus.tag_data    = tag_data_q;
  assign bus.tag_valid   = tag_valid_q;
  assign bus.done        = done_q;
  assign bus.done_data   = done_data_q;
endmodule
